// File: rtl/switch_read_sequencer.sv
// Stalls a CPU read of the DIP-switch IO window until a debounced button press/release, then returns formatted switch data.
// Optional build macro: SWITCH_TIMEOUT_EN enables the WAIT_PRESS abort counter and the io_timeout pulse.
module switch_read_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned TIMEOUT_CYCLES  = 500_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SwitchCtrl,
   input  logic [31:0] address,
   input  logic [15:0] switch_input,
   input  logic        confirmation,
   output logic [15:0] data_IO_input,
   output logic        io_stall,
   output logic        io_done,
   output logic        io_timeout,
   output logic        waiting_led,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, DONE} state_t;

   localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

   state_t      state_q, state_d;
   logic        conf_s1_q, conf_s2_q;
   logic [15:0] sw_s1_q, sw_s2_q;
   logic        btn_stable_q, btn_stable_d;
   logic [19:0] db_cnt_q, db_cnt_d;
   logic [3:0]  addr_q, addr_d;
   logic [15:0] sw_q, sw_d;
   logic [15:0] data_q, data_d;
   logic        btn_rise;
   logic        in_window;
   logic        tmo_hit;

   function automatic logic [15:0] fmt(input logic [3:0] sel, input logic [15:0] sw);
      logic [15:0] r;
      r = 16'h0000;
      case (sel)
         4'h1:    r = sw;
         4'h3:    r = {{8{sw[15]}}, sw[15:8]};
         4'h5:    r = {8'h00, sw[15:8]};
         4'h7:    r = {13'h0000, sw[2:0]};
         4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF:
                  r = {8'h00, sw[7:0]};
         default: r = 16'h0000;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         conf_s1_q    <= 1'b0;
         conf_s2_q    <= 1'b0;
         sw_s1_q      <= 16'h0000;
         sw_s2_q      <= 16'h0000;
         btn_stable_q <= 1'b0;
         db_cnt_q     <= 20'd0;
         addr_q       <= 4'h0;
         sw_q         <= 16'h0000;
         data_q       <= 16'h0000;
      end else begin
         state_q      <= state_d;
         conf_s1_q    <= confirmation;
         conf_s2_q    <= conf_s1_q;
         sw_s1_q      <= switch_input;
         sw_s2_q      <= sw_s1_q;
         btn_stable_q <= btn_stable_d;
         db_cnt_q     <= db_cnt_d;
         addr_q       <= addr_d;
         sw_q         <= sw_d;
         data_q       <= data_d;
      end
   end

   // The accepted level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
   always_comb begin
      btn_stable_d = btn_stable_q;
      db_cnt_d     = 20'd0;
      if (conf_s2_q != btn_stable_q) begin
         if (db_cnt_q == DB_LAST) btn_stable_d = conf_s2_q;
         else                     db_cnt_d     = db_cnt_q + 20'd1;
      end
   end

   // Only a fresh 0->1 flip counts, so a button already held on entry must release first.
   assign btn_rise  = ~btn_stable_q & btn_stable_d;
   assign in_window = (address[31:4] == 28'hFFF_FFFF) && (address[3:0] != 4'h0);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      sw_d    = sw_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (SwitchCtrl) begin
               if (in_window) begin
                  addr_d  = address[3:0];
                  state_d = WAIT_PRESS;
               end else begin
                  data_d  = 16'h0000;
                  state_d = DONE;
               end
            end
         end
         WAIT_PRESS: begin
            if (btn_rise) begin
               sw_d    = sw_s2_q;
               state_d = WAIT_RELEASE;
            end else if (tmo_hit) begin
               data_d  = 16'h0000;
               state_d = DONE;
            end
         end
         WAIT_RELEASE: begin
            if (!btn_stable_q) begin
               data_d  = fmt(addr_q, sw_q);
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef SWITCH_TIMEOUT_EN
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

   logic [31:0] tmo_cnt_q, tmo_cnt_d;
   logic        timeout_q, timeout_d;

   // Counts only while WAIT_PRESS persists; any state change restarts it.
   always_comb begin
      tmo_cnt_d = 32'd0;
      if (state_q == WAIT_PRESS && state_d == WAIT_PRESS) tmo_cnt_d = tmo_cnt_q + 32'd1;
      timeout_d = (state_q == WAIT_PRESS) && !btn_rise && tmo_hit;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt_q <= 32'd0;
         timeout_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign tmo_hit    = (tmo_cnt_q == TMO_LAST);
   assign io_timeout = io_done & timeout_q;
`else
   assign tmo_hit    = 1'b0;
   assign io_timeout = 1'b0;
`endif

   assign io_done       = (state_q == DONE);
   assign io_stall      = SwitchCtrl & ~io_done;
   assign waiting_led   = (state_q == WAIT_PRESS) || (state_q == WAIT_RELEASE);
   assign data_IO_input = data_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_switch_read_sequencer.sv
// Bench for switch_read_sequencer: directed spec cases plus random reads against a formatting model and expected queue.
module tb_switch_read_sequencer;

   localparam int DB  = 4;
   localparam int TMO = 50;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        SwitchCtrl = 1'b0;
   logic [31:0] address = 32'h0;
   logic [15:0] switch_input = 16'h0;
   logic        confirmation = 1'b0;
   logic [15:0] data_IO_input;
   logic        io_stall, io_done, io_timeout, waiting_led;
   logic [1:0]  state_dbg;

   int total = 0;
   int passed = 0;
   int fail_cnt = 0;
   logic [15:0] exp_q[$];
   logic [15:0] last_exp = 16'h0;

   switch_read_sequencer #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .SwitchCtrl(SwitchCtrl), .address(address),
      .switch_input(switch_input), .confirmation(confirmation),
      .data_IO_input(data_IO_input), .io_stall(io_stall), .io_done(io_done),
      .io_timeout(io_timeout), .waiting_led(waiting_led), .state_dbg(state_dbg)
   );

   // clock
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog");
   end

   // reference model: read formatting computed arithmetically from the sub-address
   function automatic logic [15:0] ref_fmt(input logic [31:0] a, input logic [15:0] sw);
      int unsigned hi, n;
      hi = int'(sw) / 256;
      n  = int'(a % 16);
      if (a < 32'hFFFF_FFF1) return 16'h0;
      case (n)
         1:          return sw;
         3:          return 16'(hi >= 128 ? hi + 32'hFF00 : hi);
         5:          return 16'(hi);
         7:          return 16'(int'(sw) % 8);
         2, 4, 6, 8: return 16'h0;
         default:    return 16'(int'(sw) % 256);
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fail_cnt++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic request(input logic [31:0] a, input logic [15:0] sw);
      address      = a;
      switch_input = sw;
      SwitchCtrl   = 1'b1;
      exp_q.push_back(ref_fmt(a, sw));
   endtask

   task automatic press_release(input int hold, input bit change_sw);
      confirmation = 1'b1;
      tick(hold);
      if (change_sw) switch_input = ~switch_input;
      tick(2);
      confirmation = 1'b0;
   endtask

   // scoreboard: waits (bounded) for io_done, compares against the expected queue, then drops the request
   task automatic wait_done(input string tag, input int budget, input logic exp_to);
      int   n = 0;
      logic seen = 1'b0;
      logic stall_ok = 1'b1;
      logic [15:0] e;
      while (!seen && n < budget) begin
         @(negedge clk);
         if (io_done) seen = 1'b1;
         else begin
            if (!io_stall) stall_ok = 1'b0;
            n++;
         end
      end
      check($sformatf("%s_done", tag), seen, 1);
      check($sformatf("%s_stall_before_done", tag), stall_ok, 1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      if (seen) begin
         check($sformatf("%s_data", tag), data_IO_input, e);
         check($sformatf("%s_timeout", tag), io_timeout, exp_to);
         check($sformatf("%s_stall_low_at_done", tag), io_stall, 0);
         last_exp = e;
      end
      @(posedge clk);
      #1;
      SwitchCtrl = 1'b0;
   endtask

   task automatic quiet(input string tag, input int n);
      int dones = 0;
      repeat (n) begin
         @(negedge clk);
         if (io_done) dones++;
      end
      check($sformatf("%s_no_done", tag), dones, 0);
      check($sformatf("%s_led", tag), waiting_led, 1);
      check($sformatf("%s_stall", tag), io_stall, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input string tag, input logic [31:0] a, input logic [15:0] sw, input bit change_sw);
      request(a, sw);
      tick(3);
      check($sformatf("%s_led", tag), waiting_led, 1);
      press_release(10, change_sw);
      wait_done(tag, 40, 1'b0);
   endtask

   initial begin
      logic [31:0] a;
      logic [15:0] sw;
      int          dones;

      // reset held with an active request
      SwitchCtrl   = 1'b1;
      address      = 32'hFFFF_FFF1;
      switch_input = 16'hA5C3;
      tick(3);
      @(negedge clk);
      check("rst_data", data_IO_input, 16'h0);
      check("rst_done", io_done, 0);
      check("rst_timeout", io_timeout, 0);
      check("rst_led", waiting_led, 0);
      check("rst_stall", io_stall, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.push_back(ref_fmt(address, switch_input));
      @(posedge clk);
      @(negedge clk);
      check("rst_release_accept", waiting_led, 1);
      tick(2);
      press_release(10, 1'b0);
      wait_done("fff1", 40, 1'b0);
      tick(3);
      check("data_held", data_IO_input, last_exp);

      do_read("fff3", 32'hFFFF_FFF3, 16'h8F00, 1'b0);

      // bouncing button must not count as a press
      request(32'hFFFF_FFF5, 16'h8F00);
      tick(3);
      for (int i = 0; i < 6; i++) begin
         confirmation = 1'b1;
         tick($urandom_range(1, DB - 1));
         confirmation = 1'b0;
         tick($urandom_range(1, 3));
      end
      quiet("bounce", 12);
      press_release(10, 1'b0);
      wait_done("fff5", 40, 1'b0);

      do_read("fff7", 32'hFFFF_FFF7, 16'h0006, 1'b0);
      do_read("fffa", 32'hFFFF_FFFA, 16'h12F4, 1'b0);
      do_read("sw_change", 32'hFFFF_FFF1, 16'h1234, 1'b1);

      // button already stable-high when the request arrives
      confirmation = 1'b1;
      tick(12);
      request(32'hFFFF_FFF1, 16'h3C5A);
      quiet("held_high", 20);
      confirmation = 1'b0;
      quiet("held_release", 12);
      press_release(10, 1'b0);
      wait_done("held", 40, 1'b0);

      // outside the window: completes one cycle after acceptance
      request(32'hFFFF_FFF0, 16'hBEEF);
      @(negedge clk);
      check("oow_not_yet", io_done, 0);
      wait_done("oow", 1, 1'b0);

`ifdef SWITCH_TIMEOUT_EN
      address    = 32'hFFFF_FFF1;
      switch_input = 16'h5A5A;
      SwitchCtrl = 1'b1;
      exp_q.push_back(16'h0);
      quiet("tmo_early", 40);
      wait_done("tmo", 20, 1'b1);
`else
      request(32'hFFFF_FFF1, 16'h0F0F);
      quiet("no_tmo", 200);
      press_release(10, 1'b0);
      wait_done("no_tmo_finish", 40, 1'b0);
`endif

      // random reads across the window
      for (int i = 0; i < 10; i++) begin
         a  = {28'hFFF_FFFF, 4'($urandom_range(1, 15))};
         sw = 16'($urandom);
         request(a, sw);
         tick($urandom_range(2, 5));
         check($sformatf("rnd%0d_led", i), waiting_led, 1);
         confirmation = 1'b1;
         tick($urandom_range(8, 14));
         confirmation = 1'b0;
         wait_done($sformatf("rnd%0d", i), 40, 1'b0);
         tick($urandom_range(0, 3));
      end

      // reset in WAIT_RELEASE aborts the read without io_done
      address      = 32'hFFFF_FFF9;
      switch_input = 16'h7777;
      SwitchCtrl   = 1'b1;
      tick(3);
      confirmation = 1'b1;
      tick(10);
      confirmation = 1'b0;
      tick(2);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_done", io_done, 0);
      check("midrst_led", waiting_led, 0);
      check("midrst_data", data_IO_input, 16'h0);
      SwitchCtrl = 1'b0;
      tick(2);
      rst = 1'b1;
      dones = 0;
      repeat (12) begin
         @(negedge clk);
         if (io_done) dones++;
      end
      check("midrst_no_done_after", dones, 0);

      // final report
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
